quad_encoder_emitter: RTL and testbench
=======================================

Name: quad_encoder_emitter

Overview:
- Generates two-phase quadrature signals (enc_a, enc_b) for a rotary encoder, one Gray-code transition per accepted step command.
- Can inject pseudo-random contact bounce on the changing line after each transition.
- Acts as the transmitting end of the input-conditioning path: it drives the debounce and encoder-decoder chain in benches and in on-chip self-test.

Parameters:
- PHASE_CYCLES, 16: clean hold cycles after each transition (>=1).
- BOUNCE_CYCLES, 4: chatter cycles after each transition; 0 disables the BOUNCE state.
- LFSR_SEED, 8'hA5: reset value of the bounce LFSR (must be nonzero).

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- step_valid  input  1  step request.
- step_dir  input  1  1 = CW (A leads B), 0 = CCW.
- bounce_en  input  1  enable chatter for this step; sampled at acceptance.
- step_ready  output  1  emitter can accept a step.
- enc_a  output  1  quadrature channel A, registered.
- enc_b  output  1  quadrature channel B, registered.
- busy  output  1  step in progress.

Behaviour:
- Reset (reset high at posedge):
  - state=IDLE, q{a,b}=00, enc_a=enc_b=0, counter=0, lfsr=LFSR_SEED, stored mask=00, stored bounce_en=0.
  - step_valid is ignored while reset is high.
  - After reset: step_ready=1, busy=0.
- step_ready = (state==IDLE); busy = !step_ready. No queueing: step_valid while busy is ignored.
- Gray sequence {a,b}:
  - CW: 00->10->11->01->00.
  - CCW: 00->01->11->10->00.
  - Wraps indefinitely; exactly one bit changes per step.
- Acceptance edge (state==IDLE and step_valid high):
  - q <= next Gray code.
  - mask <= q_old ^ q_new.
  - Latch bounce_en.
  - Go to BOUNCE (counter=BOUNCE_CYCLES-1), or to HOLD if BOUNCE_CYCLES==0.
  - The new value appears on enc_a/enc_b at the same edge (zero-cycle latency from acceptance to the output change).
- BOUNCE, BOUNCE_CYCLES cycles:
  - Outputs = q ^ (mask & {2{lfsr[0] & bounce_en_latched}}).
  - The unchanged line stays constant.
  - The LFSR advances one step per cycle, only in BOUNCE: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts left, feedback into bit 0.
  - At the end, go to HOLD with counter=PHASE_CYCLES-1.
- HOLD, PHASE_CYCLES cycles:
  - Outputs = q, clean.
  - At the end, go to IDLE.
- Timing and widths:
  - step_ready is low for exactly BOUNCE_CYCLES+PHASE_CYCLES cycles after the acceptance edge.
  - Minimum accept spacing is BOUNCE_CYCLES+PHASE_CYCLES+1 cycles.
  - Counter width is clog2(max(PHASE_CYCLES,BOUNCE_CYCLES)+1). Counts down; saturates at 0 while idle.
- Reset mid-operation (any state): abort; next edge gives enc_a=enc_b=0, q=00, IDLE, LFSR reseeded. The partial step is discarded.
- bounce_en changes during BOUNCE have no effect (the latched copy is used).
- Outputs never glitch combinationally; all are derived from registers or register-decoded.

Test Plan:
- Reset, then release -> enc_a=0, enc_b=0, step_ready=1, busy=0 on the first cycle after release.
- Four CW steps, bounce_en=0, defaults -> {a,b}=10,11,01,00, each change on the acceptance edge; step_ready low 20 cycles, then high; no other output edges.
- Four CCW steps, bounce_en=0 -> {a,b}=01,11,10,00; one more CCW step wraps to 01.
- CW step from 00, bounce_en=1 -> for 4 cycles enc_a = 1 ^ lfsr[0], matching a model seeded 0xA5; enc_b stays 0; then 16 clean cycles with enc_a=1. Feeding enc_a into an 8-stage debouncer gives exactly one debounced rise.
- step_valid held high for 100 cycles, with BOUNCE_CYCLES=4 and PHASE_CYCLES=16 -> accepts at cycles 0,21,42,63,84; no steps lost or duplicated; step_valid pulses while busy are ignored.
- reset asserted on the 2nd BOUNCE cycle of a bounce_en=1 step -> next edge a=b=0, step_ready=1; the next step's chatter pattern repeats the first-step pattern (LFSR reseeded).

Source files
------------

// File: rtl/quad_encoder_emitter.sv
// Quadrature (A/B) step emitter with optional LFSR-driven contact chatter.
// Each accepted step emits one Gray transition, then chatter (BOUNCE) and a clean hold (HOLD).
module quad_encoder_emitter #(
   parameter int         PHASE_CYCLES  = 16,
   parameter int         BOUNCE_CYCLES = 4,
   parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
   input  logic clk,
   input  logic reset,
   input  logic step_valid,
   input  logic step_dir,
   input  logic bounce_en,
   output logic step_ready,
   output logic enc_a,
   output logic enc_b,
   output logic busy
);

   localparam int MAX_CYCLES = (PHASE_CYCLES > BOUNCE_CYCLES) ? PHASE_CYCLES : BOUNCE_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [CNT_W-1:0] BOUNCE_LOAD = (BOUNCE_CYCLES > 0) ? CNT_W'(BOUNCE_CYCLES - 1) : '0;
   localparam logic [CNT_W-1:0] PHASE_LOAD  = CNT_W'(PHASE_CYCLES - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BOUNCE = 2'd1;
   localparam logic [1:0] HOLD   = 2'd2;

   logic [1:0]       state, state_n;
   logic [1:0]       q, q_n;
   logic [1:0]       mask, mask_n;
   logic             ben, ben_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [7:0]       lfsr, lfsr_n;
   logic [1:0]       enc_ab, enc_ab_n;
   logic             chatter_n;

   // {a,b}: CW walks 00->10->11->01, CCW walks the reverse
   function automatic logic [1:0] gray_next(input logic [1:0] cur, input logic dir);
      case (cur)
         2'b00:   gray_next = dir ? 2'b10 : 2'b01;
         2'b10:   gray_next = dir ? 2'b11 : 2'b00;
         2'b11:   gray_next = dir ? 2'b01 : 2'b10;
         default: gray_next = dir ? 2'b00 : 2'b11;
      endcase
   endfunction

   // x^8+x^6+x^5+x^4+1 Fibonacci, shift left, feedback into bit 0
   function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
      lfsr_step = {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
   endfunction

   always_comb begin
      state_n = state;
      q_n     = q;
      mask_n  = mask;
      ben_n   = ben;
      cnt_n   = cnt;
      lfsr_n  = lfsr;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (step_valid) begin
               q_n    = gray_next(q, step_dir);
               mask_n = q ^ q_n;
               ben_n  = bounce_en;
               if (BOUNCE_CYCLES > 0) begin
                  state_n = BOUNCE;
                  cnt_n   = BOUNCE_LOAD;
               end else begin
                  state_n = HOLD;
                  cnt_n   = PHASE_LOAD;
               end
            end
         end
         BOUNCE: begin
            lfsr_n = lfsr_step(lfsr);
            if (cnt == '0) begin
               state_n = HOLD;
               cnt_n   = PHASE_LOAD;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         HOLD: begin
            if (cnt == '0) state_n = IDLE;
            else           cnt_n   = cnt - CNT_W'(1);
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
      // Outputs are precomputed from next-state values so the change lands on the accepting edge
      chatter_n = (state_n == BOUNCE) & lfsr_n[0] & ben_n;
      enc_ab_n  = q_n ^ (mask_n & {2{chatter_n}});
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         q      <= 2'b00;
         mask   <= 2'b00;
         ben    <= 1'b0;
         cnt    <= '0;
         lfsr   <= LFSR_SEED;
         enc_ab <= 2'b00;
      end else begin
         state  <= state_n;
         q      <= q_n;
         mask   <= mask_n;
         ben    <= ben_n;
         cnt    <= cnt_n;
         lfsr   <= lfsr_n;
         enc_ab <= enc_ab_n;
      end
   end

   assign step_ready = (state == IDLE);
   assign busy       = ~step_ready;
   assign enc_a      = enc_ab[1];
   assign enc_b      = enc_ab[0];

endmodule

// File: tb/tb_quad_encoder_emitter.sv
// Bench for quad_encoder_emitter: step-level behavioural model checked every cycle,
// plus directed literal checks and a randomized soak.
module tb_quad_encoder_emitter;

   localparam int         PC   = 16;
   localparam int         BC   = 4;
   localparam logic [7:0] SEED = 8'hA5;

   logic clk, reset, step_valid, step_dir, bounce_en;
   logic step_ready, enc_a, enc_b, busy;

   quad_encoder_emitter #(.PHASE_CYCLES(PC), .BOUNCE_CYCLES(BC), .LFSR_SEED(SEED)) dut (
      .clk(clk), .reset(reset), .step_valid(step_valid), .step_dir(step_dir),
      .bounce_en(bounce_en), .step_ready(step_ready), .enc_a(enc_a), .enc_b(enc_b), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_err = 0;
   bit check_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: position on the Gray wheel plus countdowns for busy and chatter time
   function automatic logic [1:0] gray_of(input int pos);
      case (pos)
         0:       gray_of = 2'b00;
         1:       gray_of = 2'b10;
         2:       gray_of = 2'b11;
         default: gray_of = 2'b01;
      endcase
   endfunction

   function automatic logic [7:0] lfsr_adv(input logic [7:0] l);
      lfsr_adv = {l[6:0], ^(l & 8'hB8)};
   endfunction

   int         m_pos = 0, m_busy = 0, m_bnc = 0, cyc = 0;
   logic       m_ben = 1'b0;
   logic [1:0] m_mask = 2'b00;
   logic [7:0] m_lfsr = SEED;
   int         acc_q[$];

   always @(posedge clk) begin
      int old;
      cyc++;
      if (reset) begin
         m_pos = 0; m_busy = 0; m_bnc = 0; m_ben = 1'b0; m_mask = 2'b00; m_lfsr = SEED;
      end else if (m_busy == 0) begin
         if (step_valid) begin
            old    = m_pos;
            m_pos  = (m_pos + (step_dir ? 1 : 3)) % 4;
            m_mask = gray_of(old) ^ gray_of(m_pos);
            m_busy = BC + PC;
            m_bnc  = BC;
            m_ben  = bounce_en;
            acc_q.push_back(cyc);
         end
      end else begin
         m_busy--;
         if (m_bnc > 0) begin
            m_bnc--;
            m_lfsr = lfsr_adv(m_lfsr);
         end
      end
   end

   always @(negedge clk) begin
      logic [1:0] exp_ab;
      if (check_en) begin
         exp_ab = gray_of(m_pos) ^ ((m_bnc > 0 && m_ben && m_lfsr[0]) ? m_mask : 2'b00);
         check("model_enc", 32'({enc_a, enc_b}), 32'(exp_ab));
         check("model_ready", 32'(step_ready), 32'(m_busy == 0));
         check("model_busy", 32'(busy), 32'(m_busy != 0));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!step_ready && n < 200) begin
         tick(1);
         n++;
      end
   endtask

   task automatic do_step(input logic dir, input logic ben);
      int n;
      wait_ready(n);
      if (n >= 200) check("ready_timeout", 32'(step_ready), 32'd1);
      step_valid = 1'b1; step_dir = dir; bounce_en = ben;
      tick(1);
      step_valid = 1'b0; bounce_en = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   logic [1:0] cw_exp  [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
   logic [1:0] ccw_exp [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
   logic       chat_exp[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      int n, rises, stab, okb, allhi;
      logic deb;
      logic samp[20];

      reset = 1'b1; step_valid = 1'b0; step_dir = 1'b0; bounce_en = 1'b0;
      tick(3);
      step_valid = 1'b1;            // ignored while reset is high
      tick(1);
      check_en = 1'b1;
      step_valid = 1'b0;
      reset = 1'b0;
      tick(1);
      check("reset_enc", 32'({enc_a, enc_b}), 32'd0);
      check("reset_ready", 32'(step_ready), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);

      // CW from 00 with chatter: seed A5 gives lfsr[0] = 1,0,1,0 -> enc_a = 0,1,0,1
      do_step(1'b1, 1'b1);
      okb = 1; allhi = 1;
      for (int i = 0; i < 20; i++) begin
         samp[i] = enc_a;
         if (enc_b !== 1'b0) okb = 0;
         if (i >= 4 && enc_a !== 1'b1) allhi = 0;
         if (i < 4) check($sformatf("chatter_%0d", i), 32'(enc_a), 32'(chat_exp[i]));
         tick(1);
      end
      check("chatter_b_quiet", 32'(okb), 32'd1);
      check("chatter_hold_clean", 32'(allhi), 32'd1);
      deb = 1'b0; stab = 0; rises = 0;
      for (int i = 0; i < 20; i++) begin
         if (samp[i] != deb) begin
            stab++;
            if (stab == 8) begin deb = samp[i]; stab = 0; if (deb) rises++; end
         end else stab = 0;
      end
      check("debounced_rises", 32'(rises), 32'd1);

      do_reset();
      for (int i = 0; i < 4; i++) begin
         do_step(1'b1, 1'b0);
         check($sformatf("cw_step_%0d", i), 32'({enc_a, enc_b}), 32'(cw_exp[i]));
         wait_ready(n);
         check($sformatf("cw_busy_len_%0d", i), 32'(n), 32'(BC + PC));
      end
      for (int i = 0; i < 4; i++) begin
         do_step(1'b0, 1'b0);
         check($sformatf("ccw_step_%0d", i), 32'({enc_a, enc_b}), 32'(ccw_exp[i]));
      end
      do_step(1'b0, 1'b0);
      check("ccw_wrap", 32'({enc_a, enc_b}), 32'b01);

      // step_valid held high: accepts every BC+PC+1 cycles
      wait_ready(n);
      acc_q.delete();
      step_valid = 1'b1; step_dir = 1'b1;
      tick(100);
      step_valid = 1'b0;
      check("held_accept_count", 32'(acc_q.size()), 32'd5);
      for (int i = 1; i < acc_q.size(); i++)
         check($sformatf("held_spacing_%0d", i), 32'(acc_q[i] - acc_q[i-1]), 32'd21);

      // Reset on the 2nd chatter cycle reseeds the LFSR
      do_reset();
      do_step(1'b1, 1'b1);
      tick(1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("midreset_enc", 32'({enc_a, enc_b}), 32'd0);
      check("midreset_ready", 32'(step_ready), 32'd1);
      do_step(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("reseed_chatter_%0d", i), 32'(enc_a), 32'(chat_exp[i]));
         tick(1);
      end

      // Randomized soak against the model
      for (int i = 0; i < 3000; i++) begin
         step_valid = ($urandom_range(0, 2) == 0);
         step_dir   = 1'($urandom_range(0, 1));
         bounce_en  = 1'($urandom_range(0, 1));
         reset      = ($urandom_range(0, 299) == 0);
         tick(1);
      end
      reset = 1'b0; step_valid = 1'b0;
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
